// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing and framebuffer geometry shared by the timing generator and the scanout stage
package vga_pkg;
    localparam int H_ACTIVE    = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 88;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE    = 480;
    localparam int V_FP        = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 9;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SCALE_SHIFT = 2;
    localparam int FB_W        = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H        = V_ACTIVE >> SCALE_SHIFT;
    localparam int FB_SIZE     = FB_W * FB_H;
    localparam int ADDR_W      = $clog2(FB_SIZE);

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic fs;
        logic vb;
    } sideband_t;

    // y*160 + x as two shifts and an add: 160 = 128 + 32
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [9:0] x, input logic [9:0] y);
        logic [ADDR_W-1:0] xs;
        logic [ADDR_W-1:0] ys;
        xs = ADDR_W'(x >> SCALE_SHIFT);
        ys = ADDR_W'(y >> SCALE_SHIFT);
        return (ys << 7) + (ys << 5) + xs;
    endfunction
endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port framebuffer RAM, one write port, registered read-before-write read port
//   clk            pixel clock
//   we/waddr/wdata write strobe, address, pixel; addresses >= FB_SIZE are dropped
//   raddr          read address, sampled every clock
//   rdata          registered read data (old contents on a same-address write)
module fb_ram
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [2:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [2:0]        rdata
);
    logic [2:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we && waddr < ADDR_W'(FB_SIZE))
            r_mem[waddr] <= wdata;
        rdata <= r_mem[raddr];
    end
endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 4x upscaled 160x120x3 framebuffer scanout with matched hs/vs, latency 2
//   clk, rst               pixel clock, synchronous active-high reset
//   cx, cy, hs_in, vs_in   timing generator counters and syncs
//   wr_en, wr_addr, wr_data CPU framebuffer write port (linear y*FB_W+x)
//   rgb                    pixel to DAC, 0 in blanking
//   hs, vs                 syncs delayed by 2
//   frame_start            pulse when pixel (0,0) is on rgb
//   vblank                 output-stage line >= V_ACTIVE
module vga_fb_scanout
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        cx,
    input  logic [9:0]        cy,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    output logic [2:0]        rgb,
    output logic              hs,
    output logic              vs,
    output logic              frame_start,
    output logic              vblank
);
    sideband_t         w_sb0;
    sideband_t         r_sb1;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_ram_q;

    always_comb begin
        w_sb0.active = cx < 10'(H_ACTIVE) && cy < 10'(V_ACTIVE);
        w_sb0.hs     = hs_in;
        w_sb0.vs     = vs_in;
        w_sb0.fs     = cx == 10'd0 && cy == 10'd0;
        w_sb0.vb     = cy >= 10'(V_ACTIVE);
        w_addr       = fb_addr(cx, cy);
    end

    // the RAM's read-address register is the S0 register; its output is S1
    fb_ram u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (w_addr),
        .rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb1       <= '0;
            rgb         <= 3'b000;
            hs          <= 1'b0;
            vs          <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            r_sb1       <= w_sb0;
            rgb         <= r_sb1.active ? w_ram_q : 3'b000;
            hs          <= r_sb1.hs;
            vs          <= r_sb1.vs;
            frame_start <= r_sb1.fs;
            vblank      <= r_sb1.vb;
        end
    end
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: directed scoreboard bench for vga_fb_scanout
module tb_vga_fb_scanout;
    import vga_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        cx = '0;
    logic [9:0]        cy = '0;
    logic              hs_in = 1'b0;
    logic              vs_in = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [2:0]        wr_data = '0;
    logic [2:0]        rgb;
    logic              hs;
    logic              vs;
    logic              frame_start;
    logic              vblank;

    vga_fb_scanout dut (
        .clk         (clk),
        .rst         (rst),
        .cx          (cx),
        .cy          (cy),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rgb         (rgb),
        .hs          (hs),
        .vs          (vs),
        .frame_start (frame_start),
        .vblank      (vblank)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [6:0] exp;
        string      name;
        int         x;
        int         y;
    } item_t;

    item_t      sb[$];
    item_t      mon_it;
    logic [2:0] mdl [FB_SIZE];
    int         n_vec = 0;
    int         n_err = 0;

    // one pixel clock of stimulus; expected {rgb,hs,vs,frame_start,vblank} is due 2 clocks later
    task automatic drive(input bit r, input int x, input int y, input bit we, input int wa,
                         input logic [2:0] wd, input bit chk, input string nm);
        item_t it;
        bit    act;
        @(posedge clk);
        #1;
        rst     = r;
        cx      = 10'(x);
        cy      = 10'(y);
        hs_in   = x >= 656 && x < 752;
        vs_in   = y >= 490 && y < 492;
        wr_en   = we;
        wr_addr = ADDR_W'(wa);
        wr_data = wd;
        act     = x < 640 && y < 480;
        it.due  = cyc + 2;
        it.name = nm;
        it.x    = x;
        it.y    = y;
        if (r)
            it.exp = 7'd0;
        else
            it.exp = {act ? mdl[(y / 4) * 160 + x / 4] : 3'b000, hs_in, vs_in,
                      x == 0 && y == 0, y >= 480};
        if (chk) sb.push_back(it);
        if (we && wa < FB_SIZE) mdl[wa] = wd;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_it = sb.pop_front();
            n_vec++;
            if (mon_it.due != cyc) begin
                n_err++;
                $display("FAIL %s missed cx=%0d cy=%0d due=%0d now=%0d", mon_it.name, mon_it.x, mon_it.y, mon_it.due, cyc);
            end else if ({rgb, hs, vs, frame_start, vblank} !== mon_it.exp) begin
                n_err++;
                $display("FAIL %s cx=%0d cy=%0d got rgb,hs,vs,fs,vb=%b want %b", mon_it.name, mon_it.x, mon_it.y,
                         {rgb, hs, vs, frame_start, vblank}, mon_it.exp);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(1, i * 300, i * 200, 0, 0, 3'b000, 1, "reset");
        for (int a = 0; a < FB_SIZE; a++) drive(0, 700, 490, 1, a, 3'(a ^ (a >> 3) ^ (a >> 7)), 0, "fill");
        drive(0, 700, 490, 1, 0, 3'b101, 0, "w0");
        drive(0, 700, 490, 1, 1, 3'b011, 0, "w1");
        for (int x = 0; x < 5; x++) drive(0, x, 0, 0, 0, 3'b000, 1, "pix");
        drive(0, 700, 490, 1, 19199, 3'b111, 0, "w19199");
        drive(0, 636, 476, 0, 0, 3'b000, 1, "corner");
        drive(0, 640, 476, 0, 0, 3'b000, 1, "blank");
        drive(0, 640, 0, 1, 19200, 3'b111, 1, "oob");
        for (int y = 0; y < FB_H; y++)
            for (int x = 0; x < FB_W; x++)
                drive(0, x * 4 + (y & 3), y * 4 + (x & 3), 0, 0, 3'b000, 1, "readback");
        drive(0, 700, 490, 1, 5, 3'b001, 0, "w5");
        drive(0, 20, 0, 1, 5, 3'b010, 1, "rbw");
        drive(0, 21, 0, 0, 0, 3'b000, 1, "rbw_next");
        for (int y = 0; y < V_TOTAL; y++)
            if (y < 2 || y >= 478)
                for (int x = 0; x < H_TOTAL; x++) drive(0, x, y, 0, 0, 3'b000, 1, "sweep");
        for (int x = 0; x < 4; x++) drive(0, x, 0, 0, 0, 3'b000, 1, "wrap");
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
